jtframe_pocket_vmode: RTL

- Sits after the Pocket video formatter and before the Pocket video output pins.
- Measures the active geometry of the formatted stream: DE-high pixels per line, and lines with DE high per frame.
- Matches the measured geometry against up to four configured modes. After a run of stable frames it locks and selects a scaler slot.
- Once per frame, while locked, inserts the slot-select command word into the blanking RGB. Video is otherwise passed through with a fixed one-cycle delay.

---
 rtl/jtframe_pocket_vmode.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/jtframe_pocket_vmode.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_pocket_vmode
// Brief   : Measures the active geometry of the Pocket formatted video
//           stream, locks onto a configured mode after a run of stable
//           frames, and inserts a once-per-frame scaler slot-select command
//           into the blanking RGB. Video passes through with a 1-pixel delay.
//           Optional macro JTFRAME_POCKET_VMODE_ROT_EN adds the rot input
//           (rotated matching, slots 4..7).
// Revision: 1.0 - initial release
// ============================================================================
module jtframe_pocket_vmode #(
  parameter int          MODES    = 4,
  parameter logic [79:0] MODE_TBL = 80'd0,
  parameter int          STABLE   = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        de,
  input  logic        hs,
  input  logic        vs,
`ifdef JTFRAME_POCKET_VMODE_ROT_EN
  input  logic        rot,
`endif
  input  logic [23:0] rgb_in,
  output logic [23:0] rgb_out,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic [2:0]  slot,
  output logic        locked,
  output logic [9:0]  width,
  output logic [9:0]  height
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    QUALIFY = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] STABLE_W = 4'(STABLE);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;

  state_t      state, state_nxt;
  logic [9:0]  wcnt, hcnt, lwidth;
  logic        de_l, armed;
  logic [2:0]  cand, cand_nxt, slot_nxt;
  logic [3:0]  run, run_nxt;
  logic        frame_end, de_fall, rot_s, hit, cmd;
  logic [2:0]  idx;
  logic [19:0] key;

`ifdef JTFRAME_POCKET_VMODE_ROT_EN
  assign rot_s = rot;
`else
  assign rot_s = 1'b0;
`endif

  assign frame_end = pxl_cen & vs;
  assign de_fall   = de_l & ~de;
  // Geometry seen at this vs: the latched line width and the lines counted
  // so far (a line whose de falls on the vs strobe itself is not included).
  assign key       = rot_s ? {hcnt, lwidth} : {lwidth, hcnt};
  // The command rides on the first hs after vs (or the vs strobe itself if
  // hs coincides) and reflects the lock state as updated by that vs.
  assign cmd       = hs & (armed | vs) & ~de & (state_nxt == LOCKED);

  // Lowest-index table entry equal to the measured geometry
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int k = 3; k >= 0; k--) begin
      if (k < MODES && key == MODE_TBL[20*k +: 20]) begin
        hit = 1'b1;
        idx = {rot_s, k[1:0]};
      end
    end
  end

  // Lock FSM next state, evaluated only at frame end
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    run_nxt   = run;
    slot_nxt  = slot;
    if (frame_end) begin
      case (state)
        SEARCH: begin
          if (hit) begin
            cand_nxt = idx;
            run_nxt  = 4'd1;
            if (STABLE == 1) begin
              state_nxt = LOCKED;
              slot_nxt  = idx;
            end else begin
              state_nxt = QUALIFY;
            end
          end
        end
        QUALIFY: begin
          if (!hit) begin
            state_nxt = SEARCH;
            run_nxt   = 4'd0;
          end else if (idx == cand) begin
            run_nxt = run + 4'd1;
            if (run + 4'd1 == STABLE_W) begin
              state_nxt = LOCKED;
              slot_nxt  = cand;
            end
          end else begin
            cand_nxt = idx;
            run_nxt  = 4'd1;
          end
        end
        LOCKED: begin
          if (!(hit && idx == cand)) begin
            state_nxt = SEARCH;
            slot_nxt  = 3'd0;
            run_nxt   = 4'd0;
          end
        end
        default: begin
          state_nxt = SEARCH;
          slot_nxt  = 3'd0;
          run_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Lock FSM state and registered lock outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SEARCH;
      cand   <= 3'd0;
      run    <= 4'd0;
      slot   <= 3'd0;
      locked <= 1'b0;
    end else if (pxl_cen) begin
      state  <= state_nxt;
      cand   <= cand_nxt;
      run    <= run_nxt;
      slot   <= slot_nxt;
      locked <= (state_nxt == LOCKED);
    end
  end

  // Width/height measurement and per-frame command arming
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_l   <= 1'b0;
      wcnt   <= 10'd0;
      hcnt   <= 10'd0;
      lwidth <= 10'd0;
      width  <= 10'd0;
      height <= 10'd0;
      armed  <= 1'b0;
    end else if (pxl_cen) begin
      de_l <= de;
      if (hs) wcnt <= 10'd0;
      else if (de && wcnt != CNT_MAX) wcnt <= wcnt + 10'd1;
      if (de_fall) lwidth <= wcnt;
      if (vs) begin
        height <= hcnt;
        width  <= lwidth;
        hcnt   <= 10'd0;
      end else if (de_fall && hcnt != CNT_MAX) begin
        hcnt <= hcnt + 10'd1;
      end
      if (hs) armed <= 1'b0;
      else if (vs) armed <= 1'b1;
    end
  end

  // One-pixel video pipeline with blanking replaced by zero or the command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out <= 24'd0;
      de_out  <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
    end else if (pxl_cen) begin
      de_out  <= de;
      hs_out  <= hs;
      vs_out  <= vs;
      if (de)       rgb_out <= rgb_in;
      else if (cmd) rgb_out <= {21'd0, slot_nxt};
      else          rgb_out <= 24'd0;
    end
  end

endmodule
`default_nettype wire
